// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the asynchronous FIFO read side.
// Used by fifo_rd_fwft and fwft_buf_2e.
package fifo_pkg;

   localparam int unsigned FIFO_RD_LAT   = 1;   // RAM read data valid one cycle after an accepted read
   localparam int unsigned FWFT_DEPTH    = 2;   // output buffer entries
   localparam int unsigned RST_GUARD_CYC = 2;   // cycles r_en stays low after reset release
   localparam int unsigned FIFO_CNT_W    = 16;  // delivered-word counter width

   typedef logic [1:0] fwft_occ_t;

   // True when one more read can be issued without the returning word
   // overflowing the output buffer: stored + in flight - leaving now < depth.
   function automatic logic fwft_issue_ok(input fwft_occ_t occ,
                                          input logic      inflight,
                                          input logic      pop);
      logic [2:0] load;
      load = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
      return (load < 3'(FWFT_DEPTH));
   endfunction

endpackage

// File: rtl/fifo_rd_fwft_buf.sv
// fwft_buf_2e: 2-entry circular output buffer for the FWFT read adapter.
// Registered head word, occupancy count and valid flag.
module fwft_buf_2e
   import fifo_pkg::*;
#(
   parameter int unsigned DW = 8
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          wr_en_i,
   input  logic [DW-1:0] wr_data_i,
   input  logic          rd_en_i,
   output fwft_occ_t     occ_o,
   output logic          valid_o,
   output logic [DW-1:0] data_o
);

   logic [DW-1:0] mem_q [FWFT_DEPTH];
   logic [DW-1:0] mem_d [FWFT_DEPTH];
   logic          wr_ptr_q, wr_ptr_d;
   logic          rd_ptr_q, rd_ptr_d;
   fwft_occ_t     occ_q, occ_d;
   logic [DW-1:0] dout_q, dout_d;
   logic          rd;

   // Next-state: write at wr_ptr, advance rd_ptr on pop, head word follows rd_ptr
   always_comb begin
      for (int unsigned i = 0; i < FWFT_DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      rd       = rd_en_i & (occ_q != 2'd0);
      if (wr_en_i) begin
         mem_d[wr_ptr_q] = wr_data_i;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (rd) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({wr_en_i, rd})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
      // Registered head: look ahead through the post-write array so a word
      // written into an empty buffer shows up the very next cycle.
      dout_d = mem_d[rd_ptr_d];
   end

   // State registers, cleared asynchronously
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < FWFT_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= '0;
         dout_q   <= '0;
      end else begin
         for (int unsigned i = 0; i < FWFT_DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         dout_q   <= dout_d;
      end
   end

   // Output mapping
   always_comb begin
      occ_o   = occ_q;
      valid_o = (occ_q != 2'd0);
      data_o  = dout_q;
   end

   // A capture into a full buffer without a simultaneous pop would lose a word
   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(wr_en_i && (occ_q == 2'd2) && !rd_en_i));

endmodule

// File: rtl/fifo_rd_fwft.sv
// fifo_rd_fwft: first-word-fall-through read adapter for the async FIFO.
// Issues r_en from r_empty and buffer space, captures r_data one cycle
// later into a 2-entry buffer, presents a valid/ready stream.
// Optional macro FWFT_STAT_EN adds the 16-bit delivered-word counter rd_cnt.
module fifo_rd_fwft
   import fifo_pkg::*;
#(
   parameter int unsigned DW = 8
) (
   input  logic                  r_clk,
   input  logic                  rst_n,
   input  logic                  r_empty,
   output logic                  r_en,
   input  logic [DW-1:0]         r_data,
   output logic                  m_valid,
   output logic [DW-1:0]         m_data,
   input  logic                  m_ready
`ifdef FWFT_STAT_EN
   ,
   output logic [FIFO_CNT_W-1:0] rd_cnt
`endif
);

   localparam logic [1:0] GUARD_MAX = 2'(RST_GUARD_CYC);

   logic [1:0] guard_q, guard_d;
   logic       guard_done;
   logic       inflight_q, inflight_d;
   logic       acc_rd;
   logic       pop;
   fwft_occ_t  occ;

   // Read issue: only after the guard, only if the returning word will fit
   always_comb begin
      guard_done = (guard_q == GUARD_MAX);
      pop        = m_valid & m_ready;
      r_en       = guard_done & ~r_empty & fwft_issue_ok(occ, inflight_q, pop);
      acc_rd     = r_en & ~r_empty;
   end

   // Next-state for the reset guard and the in-flight flag
   always_comb begin
      guard_d    = (guard_q == GUARD_MAX) ? guard_q : guard_q + 2'd1;
      inflight_d = acc_rd;
   end

   // Guard and in-flight registers; an in-flight word is dropped on reset
   always_ff @(posedge r_clk or negedge rst_n) begin
      if (!rst_n) begin
         guard_q    <= '0;
         inflight_q <= 1'b0;
      end else begin
         guard_q    <= guard_d;
         inflight_q <= inflight_d;
      end
   end

   fwft_buf_2e #(
      .DW (DW)
   ) u_buf (
      .clk_i     (r_clk),
      .rst_ni    (rst_n),
      .wr_en_i   (inflight_q),
      .wr_data_i (r_data),
      .rd_en_i   (pop),
      .occ_o     (occ),
      .valid_o   (m_valid),
      .data_o    (m_data)
   );

`ifdef FWFT_STAT_EN
   logic [FIFO_CNT_W-1:0] rd_cnt_q, rd_cnt_d;

   // Delivered-word count, wraps naturally at the top
   always_comb begin
      rd_cnt_d = rd_cnt_q;
      if (pop) begin
         rd_cnt_d = rd_cnt_q + FIFO_CNT_W'(1);
      end
      rd_cnt = rd_cnt_q;
   end

   // Counter register
   always_ff @(posedge r_clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_cnt_q <= '0;
      end else begin
         rd_cnt_q <= rd_cnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// Bench for fifo_rd_fwft: queue-based model of source FIFO and output stream.
// Honours FWFT_STAT_EN for the rd_cnt checks.
module tb_fifo_rd_fwft;

   logic        r_clk = 1'b0;
   logic        rst_n;
   logic        r_empty;
   logic        r_en;
   logic [7:0]  r_data;
   logic        m_valid;
   logic [7:0]  m_data;
   logic        m_ready;
`ifdef FWFT_STAT_EN
   logic [15:0] rd_cnt;
`endif

   always #5 r_clk = ~r_clk;

   fifo_rd_fwft #(
      .DW (8)
   ) dut (
      .r_clk   (r_clk),
      .rst_n   (rst_n),
      .r_empty (r_empty),
      .r_en    (r_en),
      .r_data  (r_data),
      .m_valid (m_valid),
      .m_data  (m_data),
      .m_ready (m_ready)
`ifdef FWFT_STAT_EN
      ,
      .rd_cnt  (rd_cnt)
`endif
   );

   int          n_chk = 0;
   int          n_pass = 0;
   int          cyc = 0;

   // Environment: words waiting in the FIFO, and every word ever written in order
   logic [7:0]  src[$];
   logic [7:0]  sent[$];
   // Model: words held in the adapter's output buffer, plus the word in flight
   logic [7:0]  obuf[$];
   logic        inf = 1'b0;
   logic [7:0]  inf_word = 8'h00;
   int          guard = 0;
   logic [15:0] cnt_m = 16'h0000;
   int          acc_cnt = 0;
   logic        force_empty = 1'b0;
   logic        force_nonempty = 1'b0;
   int          mark_ren = -1;
   int          mark_mv = -1;
   logic [7:0]  got[$];
   int          got_cyc[$];
   int          a0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic push(input logic [7:0] w);
      src.push_back(w);
      sent.push_back(w);
   endtask

   task automatic model_reset();
      obuf.delete();
      src.delete();
      sent.delete();
      inf   = 1'b0;
      guard = 0;
      cnt_m = 16'h0000;
   endtask

   // One r_clk cycle: drive inputs after the negedge, compare, advance model
   task automatic step(input logic mr);
      logic       exp_valid, exp_pop, exp_ren, acc;
      logic [2:0] load;
      logic [31:0] exp_w;
      m_ready = mr;
      r_empty = force_nonempty ? 1'b0 : (force_empty || (src.size() == 0));
      r_data  = inf ? inf_word : 8'hA5;
      #1;
      exp_valid = (obuf.size() != 0);
      exp_pop   = exp_valid && mr;
      load      = 3'(obuf.size()) + 3'(inf) - 3'(exp_pop);
      exp_ren   = (guard >= 2) && !r_empty && (load < 3'd2);
      chk("r_en", 32'(r_en), 32'(exp_ren));
      chk("m_valid", 32'(m_valid), 32'(exp_valid));
      if (exp_valid) chk("m_data", 32'(m_data), 32'(obuf[0]));
`ifdef FWFT_STAT_EN
      chk("rd_cnt", 32'(rd_cnt), 32'(cnt_m));
`endif
      if (r_en === 1'b1 && mark_ren < 0) mark_ren = cyc;
      if (m_valid === 1'b1 && mark_mv < 0) mark_mv = cyc;
      if (m_valid === 1'b1 && mr) begin
         got.push_back(m_data);
         got_cyc.push_back(cyc);
         if (sent.size() != 0) exp_w = 32'(sent.pop_front());
         else exp_w = 32'hDEAD;
         chk("order", 32'(m_data), exp_w);
      end
      if (exp_pop) begin
         void'(obuf.pop_front());
         cnt_m = cnt_m + 16'd1;
      end
      if (inf) obuf.push_back(inf_word);
      if (obuf.size() > 2) chk("model_occ", 32'(obuf.size()), 32'd2);
      acc = (r_en === 1'b1) && !r_empty;
      inf = acc;
      if (acc) begin
         if (src.size() != 0) inf_word = src.pop_front();
         else inf_word = 8'hEE;
         acc_cnt++;
      end
      @(posedge r_clk);
      if (rst_n && guard < 2) guard++;
      @(negedge r_clk);
      cyc++;
   endtask

   initial begin
      rst_n   = 1'b0;
      m_ready = 1'b0;
      r_empty = 1'b0;
      r_data  = 8'h00;
      model_reset();
      repeat (3) @(negedge r_clk);
      #1;
      chk("rst_r_en", 32'(r_en), 32'd0);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_data", 32'(m_data), 32'h00);
`ifdef FWFT_STAT_EN
      chk("rst_rd_cnt", 32'(rd_cnt), 32'd0);
`endif
      @(negedge r_clk);
      rst_n = 1'b1;

      // Reset release while the controller still reports not-empty
      force_nonempty = 1'b1;
      step(1'b0);
      step(1'b0);
      force_nonempty = 1'b0;
      repeat (3) step(1'b0);
      chk("guard_no_reads", 32'(acc_cnt), 32'd0);

      // Three preloaded words, downstream always ready
      mark_ren = -1; mark_mv = -1; got.delete(); got_cyc.delete();
      push(8'h11); push(8'h22); push(8'h33);
      repeat (8) step(1'b1);
      chk("first_latency", 32'(mark_mv - mark_ren), 32'd2);
      chk("pre_count", 32'(got.size()), 32'd3);
      chk("pre_w0", 32'(got[0]), 32'h11);
      chk("pre_w2", 32'(got[2]), 32'h33);
      chk("pre_back2back", 32'(got_cyc[2] - got_cyc[0]), 32'd2);

      // Eight words under back-pressure, then release
      got.delete(); got_cyc.delete();
      a0 = acc_cnt;
      for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
      repeat (6) step(1'b0);
      chk("stall_reads", 32'(acc_cnt - a0), 32'd2);
      chk("stall_hold", 32'(m_data), 32'h40);
      chk("stall_r_en", 32'(r_en), 32'd0);
      repeat (12) step(1'b1);
      chk("stall_count", 32'(got.size()), 32'd8);
      chk("stall_last", 32'(got[7]), 32'h47);
      chk("stall_no_gap", 32'(got_cyc[7] - got_cyc[0]), 32'd7);

      // Alternating ready over ten words
      got.delete(); got_cyc.delete();
      for (int i = 0; i < 10; i++) push(8'(i));
      for (int i = 0; i < 40; i++) step((i % 2) == 0);
      chk("tog_count", 32'(got.size()), 32'd10);
      chk("tog_first", 32'(got[0]), 32'h00);
      chk("tog_last", 32'(got[9]), 32'h09);

      // r_empty rises right after an accepted read
      got.delete(); got_cyc.delete();
      a0 = acc_cnt;
      push(8'h5A); push(8'h5B);
      for (int i = 0; i < 10 && acc_cnt == a0; i++) step(1'b1);
      chk("empty_rise_acc", 32'(acc_cnt - a0), 32'd1);
      force_empty = 1'b1;
      repeat (5) step(1'b1);
      chk("empty_rise_count", 32'(got.size()), 32'd1);
      chk("empty_rise_word", 32'(got[0]), 32'h5A);
      chk("empty_rise_reads", 32'(acc_cnt - a0), 32'd1);
      chk("empty_rise_r_en", 32'(r_en), 32'd0);
      force_empty = 1'b0;
      repeat (6) step(1'b1);
      chk("empty_drain", 32'(got.size()), 32'd2);

      // Reset pulse with a full output buffer
      for (int i = 0; i < 4; i++) push(8'h60 + 8'(i));
      repeat (5) step(1'b0);
      chk("pre_rst_valid", 32'(m_valid), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_r_en", 32'(r_en), 32'd0);
      chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
`ifdef FWFT_STAT_EN
      chk("mid_rst_rd_cnt", 32'(rd_cnt), 32'd0);
`endif
      model_reset();
      @(negedge r_clk);
      @(negedge r_clk);
      rst_n = 1'b1;
      got.delete(); got_cyc.delete();
      repeat (4) step(1'b1);
      chk("post_rst_none", 32'(got.size()), 32'd0);

`ifdef FWFT_STAT_EN
      // Counter wrap: 65537 pops leave rd_cnt at 1
      chk("cnt_start", 32'(rd_cnt), 32'd0);
      for (int i = 0; i < 65537; i++) push(8'(i));
      got.delete(); got_cyc.delete();
      for (int i = 0; i < 65547 && (src.size() != 0 || obuf.size() != 0 || inf); i++) step(1'b1);
      repeat (2) step(1'b1);
      chk("cnt_wrap", 32'(rd_cnt), 32'd1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
